// File: rtl/mc_ctrl_fsm.sv
// mc_ctrl_fsm: multi-cycle MIPS control sequencer stepping FETCH/DECODE/EXEC/MEM/WB,
// with a memory-ready handshake, a bounded wait and an illegal-instruction trap into HALT.
module mc_ctrl_fsm #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       alu_zero,
  input  logic       mem_ready,
  output logic       IR_in,
  output logic       IR_out,
  output logic       pc_we,
  output logic [1:0] pc_src,
  output logic       mem_rd,
  output logic       mem_wr,
  output logic       rf_we,
  output logic       rf_dst_rd,
  output logic       wb_mem,
  output logic       alu_src_imm,
  output logic [2:0] alu_op,
  output logic       instr_done,
  output logic       illegal,
  output logic       bus_err,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd7
  } state_t;

  typedef enum logic [3:0] {
    I_ADDU, I_SUBU, I_AND, I_OR, I_JR, I_ADDIU, I_LW, I_SW, I_BEQ, I_J, I_BAD
  } instr_t;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;

  localparam logic [1:0] PC_SEQ  = 2'd0;
  localparam logic [1:0] PC_BR   = 2'd1;
  localparam logic [1:0] PC_JUMP = 2'd2;
  localparam logic [1:0] PC_RS   = 2'd3;

  localparam logic [4:0] TIMEOUT_LIMIT = TIMEOUT_CYCLES[4:0];

  state_t     cur;
  instr_t     instr;
  logic [4:0] wait_cnt;
  logic       wait_expired;
  logic       illegal_q;
  logic       bus_err_q;

  // NOTE: every variable written in a combinational block gets a default first,
  // otherwise an unassigned path infers a latch.
  always_comb begin
    instr = I_BAD;
    case (opcode)
      6'h00: begin
        case (funct)
          6'h21:   instr = I_ADDU;
          6'h23:   instr = I_SUBU;
          6'h24:   instr = I_AND;
          6'h25:   instr = I_OR;
          6'h08:   instr = I_JR;
          default: instr = I_BAD;
        endcase
      end
      6'h09:   instr = I_ADDIU;
      6'h23:   instr = I_LW;
      6'h2B:   instr = I_SW;
      6'h04:   instr = I_BEQ;
      6'h02:   instr = I_J;
      default: instr = I_BAD;
    endcase
  end

  assign wait_expired = (wait_cnt == TIMEOUT_LIMIT);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur       <= S_FETCH;
      wait_cnt  <= 5'd0;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      case (cur)
        S_FETCH: begin
          if (mem_ready) begin
            cur      <= S_DECODE;
            wait_cnt <= 5'd0;
          end else if (wait_expired) begin
            cur       <= S_HALT;
            bus_err_q <= 1'b1;
            wait_cnt  <= 5'd0;
          end else begin
            wait_cnt <= wait_cnt + 5'd1;
          end
        end
        S_DECODE: begin
          case (instr)
            I_BAD: begin
              cur       <= S_HALT;
              illegal_q <= 1'b1;
            end
            I_J:     cur <= S_FETCH;
            default: cur <= S_EXEC;
          endcase
        end
        S_EXEC: begin
          case (instr)
            I_BEQ, I_JR: cur <= S_FETCH;
            I_LW, I_SW:  cur <= S_MEM;
            default:     cur <= S_WB;
          endcase
        end
        S_MEM: begin
          if (mem_ready) begin
            cur      <= (instr == I_LW) ? S_WB : S_FETCH;
            wait_cnt <= 5'd0;
          end else if (wait_expired) begin
            cur       <= S_HALT;
            bus_err_q <= 1'b1;
            wait_cnt  <= 5'd0;
          end else begin
            wait_cnt <= wait_cnt + 5'd1;
          end
        end
        S_WB:    cur <= S_FETCH;
        S_HALT:  cur <= S_HALT;
        default: cur <= S_HALT;
      endcase
    end
  end

  // Strobes are gated by rst directly so they drop the moment reset rises,
  // abandoning any access in flight without waiting for a clock edge.
  always_comb begin
    IR_in       = 1'b0;
    IR_out      = 1'b0;
    pc_we       = 1'b0;
    pc_src      = PC_SEQ;
    mem_rd      = 1'b0;
    mem_wr      = 1'b0;
    rf_we       = 1'b0;
    rf_dst_rd   = 1'b0;
    wb_mem      = 1'b0;
    alu_src_imm = 1'b0;
    alu_op      = ALU_ADD;
    instr_done  = 1'b0;
    state       = 3'd0;
    if (!rst) begin
      state = cur;
      case (cur)
        S_FETCH: begin
          mem_rd = 1'b1;
          if (mem_ready) begin
            IR_in  = 1'b1;
            pc_we  = 1'b1;
            pc_src = PC_SEQ;
          end
        end
        S_DECODE: begin
          IR_out = 1'b1;
          if (instr == I_J) begin
            pc_we      = 1'b1;
            pc_src     = PC_JUMP;
            instr_done = 1'b1;
          end
        end
        S_EXEC: begin
          IR_out = 1'b1;
          case (instr)
            I_SUBU, I_BEQ: alu_op = ALU_SUB;
            I_AND:         alu_op = ALU_AND;
            I_OR:          alu_op = ALU_OR;
            default:       alu_op = ALU_ADD;
          endcase
          alu_src_imm = (instr == I_ADDIU) || (instr == I_LW) || (instr == I_SW);
          if (instr == I_BEQ) begin
            pc_we      = alu_zero;
            pc_src     = PC_BR;
            instr_done = 1'b1;
          end else if (instr == I_JR) begin
            pc_we      = 1'b1;
            pc_src     = PC_RS;
            instr_done = 1'b1;
          end
        end
        S_MEM: begin
          IR_out      = 1'b1;
          alu_src_imm = 1'b1;
          alu_op      = ALU_ADD;
          if (instr == I_LW) begin
            mem_rd = 1'b1;
          end else begin
            mem_wr     = 1'b1;
            instr_done = mem_ready;
          end
        end
        S_WB: begin
          IR_out     = 1'b1;
          rf_we      = 1'b1;
          rf_dst_rd  = (opcode == 6'h00);
          wb_mem     = (instr == I_LW);
          instr_done = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign illegal = illegal_q;
  assign bus_err = bus_err_q;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// tb_mc_ctrl_fsm: table-driven instruction vectors plus hand-written sequences
// for memory waits, timeout, illegal trap and asynchronous reset.
module tb_mc_ctrl_fsm;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode, funct;
  logic       alu_zero, mem_ready;
  logic       IR_in, IR_out, pc_we, mem_rd, mem_wr, rf_we, rf_dst_rd, wb_mem;
  logic       alu_src_imm, instr_done, illegal, bus_err;
  logic [1:0] pc_src;
  logic [2:0] alu_op, state;

  mc_ctrl_fsm #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .alu_zero(alu_zero),
    .mem_ready(mem_ready), .IR_in(IR_in), .IR_out(IR_out), .pc_we(pc_we),
    .pc_src(pc_src), .mem_rd(mem_rd), .mem_wr(mem_wr), .rf_we(rf_we),
    .rf_dst_rd(rf_dst_rd), .wb_mem(wb_mem), .alu_src_imm(alu_src_imm),
    .alu_op(alu_op), .instr_done(instr_done), .illegal(illegal),
    .bus_err(bus_err), .state(state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [14:0] strobes();
    return {IR_in, IR_out, pc_we, pc_src, mem_rd, mem_wr, rf_we, rf_dst_rd,
            wb_mem, alu_src_imm, alu_op, instr_done};
  endfunction

  // Each cycle starts 1 time unit after posedge (inputs driven) and is sampled at negedge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // aop = 7 means the instruction has no EXEC cycle or its ALU function is unspecified.
  typedef struct {
    string       name;
    logic [5:0]  op;
    logic [5:0]  fn;
    logic        zero;
    logic [19:0] trace;
    int          cycles;
    logic [2:0]  aop;
    logic        imm;
    logic        pwe;
    logic [1:0]  psrc;
    int          rfwe;
    logic        dst;
    logic        wb;
    int          rd;
    int          wr;
  } vec_t;

  vec_t vecs[11];

  task automatic run_vec(input vec_t v);
    logic [19:0] trace = '0;
    int cyc = 0, rfwe = 0, rd = 0, wr = 0, done = 0;
    logic [2:0] aop = 3'h7;
    logic imm = 1'b0, pwe = 1'b0, dst = 1'b0, wb = 1'b0, ir_ok = 1'b1, fetch_ok = 1'b1;
    logic [1:0] psrc = 2'd0;
    opcode = v.op; funct = v.fn; alu_zero = v.zero; mem_ready = 1'b1;
    for (int c = 0; c < 10 && done == 0; c++) begin
      @(negedge clk);
      trace = {trace[15:0], 1'b0, state};
      cyc++;
      if (IR_out !== (state != 3'd0 && state != 3'd7)) ir_ok = 1'b0;
      if (state == 3'd0 && !(IR_in && pc_we && pc_src == 2'd0)) fetch_ok = 1'b0;
      if (state == 3'd2) begin aop = alu_op; imm = alu_src_imm; end
      if (rf_we) begin rfwe++; dst = rf_dst_rd; wb = wb_mem; end
      rd += int'(mem_rd);
      wr += int'(mem_wr);
      if (instr_done) begin done++; pwe = pc_we; psrc = pc_src; end
      next_cycle();
    end
    check({v.name, " done"}, done, 1);
    check({v.name, " trace"}, trace, v.trace);
    check({v.name, " cycles"}, cyc, v.cycles);
    if (v.aop != 3'h7) check({v.name, " alu_op"}, aop, v.aop);
    check({v.name, " alu_src_imm"}, imm, v.imm);
    check({v.name, " retire pc_we"}, pwe, v.pwe);
    check({v.name, " retire pc_src"}, psrc, v.psrc);
    check({v.name, " rf_we cycles"}, rfwe, v.rfwe);
    check({v.name, " rf_dst_rd"}, dst, v.dst);
    check({v.name, " wb_mem"}, wb, v.wb);
    check({v.name, " mem_rd cycles"}, rd, v.rd);
    check({v.name, " mem_wr cycles"}, wr, v.wr);
    check({v.name, " IR_out"}, ir_ok, 1);
    check({v.name, " fetch strobes"}, fetch_ok, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cnt;
    int bad;
    //        name       op     fn     z  trace     cyc alu  imm pwe psrc rfwe dst wb rd wr
    vecs[0]  = '{"addu",  6'h00, 6'h21, 0, 20'h0124,  4, 3'd0, 0, 0, 2'd0, 1, 1, 0, 1, 0};
    vecs[1]  = '{"subu",  6'h00, 6'h23, 0, 20'h0124,  4, 3'd1, 0, 0, 2'd0, 1, 1, 0, 1, 0};
    vecs[2]  = '{"and",   6'h00, 6'h24, 0, 20'h0124,  4, 3'd2, 0, 0, 2'd0, 1, 1, 0, 1, 0};
    vecs[3]  = '{"or",    6'h00, 6'h25, 0, 20'h0124,  4, 3'd3, 0, 0, 2'd0, 1, 1, 0, 1, 0};
    vecs[4]  = '{"jr",    6'h00, 6'h08, 0, 20'h012,   3, 3'd7, 0, 1, 2'd3, 0, 0, 0, 1, 0};
    vecs[5]  = '{"addiu", 6'h09, 6'h00, 0, 20'h0124,  4, 3'd0, 1, 0, 2'd0, 1, 0, 0, 1, 0};
    vecs[6]  = '{"lw",    6'h23, 6'h15, 0, 20'h01234, 5, 3'd0, 1, 0, 2'd0, 1, 0, 1, 2, 0};
    vecs[7]  = '{"sw",    6'h2B, 6'h00, 0, 20'h0123,  4, 3'd0, 1, 0, 2'd0, 0, 0, 0, 1, 1};
    vecs[8]  = '{"beq_t", 6'h04, 6'h00, 1, 20'h012,   3, 3'd1, 0, 1, 2'd1, 0, 0, 0, 1, 0};
    vecs[9]  = '{"beq_nt",6'h04, 6'h00, 0, 20'h012,   3, 3'd1, 0, 0, 2'd1, 0, 0, 0, 1, 0};
    vecs[10] = '{"j",     6'h02, 6'h00, 0, 20'h01,    2, 3'd7, 0, 1, 2'd2, 0, 0, 0, 1, 0};

    rst = 1'b1; opcode = 6'h00; funct = 6'h21; alu_zero = 1'b0; mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset strobes", strobes(), 15'd0);
    check("reset state", state, 3'd0);
    check("reset flags", {illegal, bus_err}, 2'b00);
    @(posedge clk);
    #1;
    rst = 1'b0;
    mem_ready = 1'b0;
    @(negedge clk);
    check("first fetch mem_rd", mem_rd, 1'b1);
    check("fetch IR_in waits ready", IR_in, 1'b0);
    check("fetch pc_we waits ready", pc_we, 1'b0);
    next_cycle();

    for (int i = 0; i < 11; i++) run_vec(vecs[i]);

    // lw with memory ready three cycles late in MEM
    opcode = 6'h23; funct = 6'h00; mem_ready = 1'b1;
    next_cycle();
    next_cycle();
    next_cycle();
    cnt = 0;
    for (int c = 0; c < 4; c++) begin
      mem_ready = (c == 3);
      @(negedge clk);
      if (state == 3'd3 && mem_rd && !mem_wr && alu_src_imm && alu_op == 3'd0) cnt++;
      next_cycle();
    end
    check("lw slow mem_rd cycles", cnt, 4);
    @(negedge clk);
    check("lw slow WB state", state, 3'd4);
    check("lw slow WB ctrl", {rf_we, rf_dst_rd, wb_mem, instr_done}, 4'b1011);
    next_cycle();

    // asynchronous reset in the middle of a lw memory wait
    mem_ready = 1'b1;
    next_cycle();
    next_cycle();
    next_cycle();
    mem_ready = 1'b0;
    @(negedge clk);
    check("mid-MEM mem_rd before reset", {state, mem_rd}, {3'd3, 1'b1});
    #2;
    rst = 1'b1;
    #1;
    check("async reset drops strobes", strobes(), 15'd0);
    check("async reset state", state, 3'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // illegal opcode 0x3F traps into HALT and stays there
    opcode = 6'h3F; funct = 6'h00; mem_ready = 1'b1;
    next_cycle();
    @(negedge clk);
    check("illegal decode state", state, 3'd1);
    next_cycle();
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (state != 3'd7 || !illegal || bus_err || strobes() != 15'd0) bad++;
      next_cycle();
    end
    check("illegal HALT hold cycles", bad, 0);
    rst = 1'b1;
    #1;
    check("reset clears illegal", illegal, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("fetch resumes after HALT", {state, mem_rd}, {3'd0, 1'b1});

    // R-type with funct 0x00 is also illegal
    opcode = 6'h00; funct = 6'h00;
    @(posedge clk);
    #1;
    next_cycle();
    @(negedge clk);
    check("funct 0 traps", {state, illegal, bus_err}, {3'd7, 2'b10});
    next_cycle();
    pulse_reset();

    // fetch timeout: 16 missed cycles counted, limit cycle still misses
    mem_ready = 1'b0; opcode = 6'h00; funct = 6'h21;
    bad = 0;
    for (int c = 0; c < 17; c++) begin
      @(negedge clk);
      if (state != 3'd0 || bus_err || !mem_rd) bad++;
      next_cycle();
    end
    check("timeout wait in FETCH", bad, 0);
    @(negedge clk);
    check("timeout HALT", {state, bus_err, illegal}, {3'd7, 2'b10});
    check("timeout HALT strobes", strobes(), 15'd0);
    next_cycle();
    pulse_reset();

    // mem_ready exactly on the limit cycle wins over the timeout
    mem_ready = 1'b0;
    bad = 0;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if (state != 3'd0 || bus_err) bad++;
      next_cycle();
    end
    check("reset clears bus_err and waits", bad, 0);
    mem_ready = 1'b1;
    @(negedge clk);
    check("ready at limit IR_in", {IR_in, pc_we, bus_err}, 3'b110);
    next_cycle();
    @(negedge clk);
    check("ready at limit goes DECODE", {state, bus_err}, {3'd1, 1'b0});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
